// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings used by the bus interface unit and its slaves.
package ahb_pkg;

    // Transfer type (htrans)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Slave response (hresp)
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Burst type (hburst)
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic htrans_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave fronting a single-port synchronous SRAM. Handles single and
// burst beats, inserts WAIT_CYCLES wait states per data phase and answers
// out-of-range addresses with the two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int BUSD_WIDTH  = 8,
    parameter int BUSA_WIDTH  = 24,
    parameter int MEM_AW      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  hreset_n,
    input  logic                  hsel,
    input  logic [BUSA_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hburst,
    input  logic [1:0]            htrans,
    input  logic [BUSD_WIDTH-1:0] hwdata,
    output logic                  hready,
    output logic                  hresp,
    output logic [BUSD_WIDTH-1:0] hrdata,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [MEM_AW-1:0]     sram_addr,
    output logic [BUSD_WIDTH-1:0] sram_wdata,
    input  logic [BUSD_WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RDISS,
        ST_RDDAT,
        ST_WR,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Counter reload value; a zero-wait configuration never enters ST_WAIT.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t              state_q;
    state_t              state_nxt;
    logic [3:0]          wait_cnt_q;
    logic [3:0]          wait_cnt_nxt;
    logic                hready_q;
    logic                hresp_q;
    logic [MEM_AW-1:0]   addr_p1;
    logic                write_p1;
    logic                accept;
    logic                addr_err;

    // States in which the current data phase finishes (hready high).
    function automatic logic ready_of(input state_t s);
        return (s == ST_IDLE) || (s == ST_RDDAT) || (s == ST_WR) || (s == ST_ERR2);
    endfunction

    // States that drive the ERROR response.
    function automatic logic resp_of(input state_t s);
        return ((s == ST_ERR1) || (s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    endfunction

    assign accept   = hsel && htrans_active(htrans) && hready_q;
    assign addr_err = |haddr[BUSA_WIDTH-1:MEM_AW];

    // Next-state and wait-counter decode; hready-high states behave like ST_IDLE.
    always_comb begin
        state_nxt    = state_q;
        wait_cnt_nxt = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_RDDAT, ST_WR, ST_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nxt = hwrite ? ST_WR : ST_RDISS;
                    end else begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_nxt = write_p1 ? ST_WR : ST_RDISS;
                end else begin
                    wait_cnt_nxt = wait_cnt_q - 4'd1;
                end
            end
            ST_RDISS: state_nxt = ST_RDDAT;
            ST_ERR1:  state_nxt = ST_ERR2;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register with registered hready/hresp derived from the next state.
    always_ff @(posedge clk) begin
        if (!hreset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            hready_q   <= 1'b1;
            hresp_q    <= HRESP_OKAY;
        end else begin
            state_q    <= state_nxt;
            wait_cnt_q <= wait_cnt_nxt;
            hready_q   <= ready_of(state_nxt);
            hresp_q    <= resp_of(state_nxt);
        end
    end

    // ---- address phase -> data phase boundary ----
    // Address-phase capture; only meaningful while a data phase is in flight,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1  <= haddr[MEM_AW-1:0];
            write_p1 <= hwrite;
        end
    end

    assign hready = hready_q;
    assign hresp  = hresp_q;

    // SRAM strobes come only from data-phase states, so at most one access per cycle.
    assign sram_cs    = (state_q == ST_RDISS) || (state_q == ST_WR);
    assign sram_we    = (state_q == ST_WR);
    assign sram_addr  = sram_cs ? addr_p1 : '0;
    assign sram_wdata = (state_q == ST_WR) ? hwdata : '0;
    assign hrdata     = (state_q == ST_RDDAT) ? sram_rdata : '0;

    // Burst type is not decoded, but an accepted beat should still carry a defined one.
    a_hburst_known: assert property (@(posedge clk) disable iff (!hreset_n)
        accept |-> !$isunknown(hburst));

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: three instances with 0, 2 and 3 wait
// states, each backed by a behavioural SRAM. A pipelined AHB master drives
// beats from a queue; a reference memory produces expected read data and
// data-phase lengths that are pushed to a scoreboard queue and popped as each
// data phase completes.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int NI = 3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        logic        is_err;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset_n   [NI];
    logic        hsel       [NI];
    logic [23:0] haddr      [NI];
    logic        hwrite     [NI];
    logic [2:0]  hburst     [NI];
    logic [1:0]  htrans     [NI];
    logic [7:0]  hwdata     [NI];
    logic        hready     [NI];
    logic        hresp      [NI];
    logic [7:0]  hrdata     [NI];
    logic        sram_cs    [NI];
    logic        sram_we    [NI];
    logic [15:0] sram_addr  [NI];
    logic [7:0]  sram_wdata [NI];

    logic [7:0]  ref_mem [NI][0:65535];
    beat_t       bq[$];
    exp_t        eq[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            logic [7:0] rd_q;
            logic [7:0] mem [0:65535];

            initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

            always @(posedge clk) begin
                if (sram_cs[g] === 1'b1) begin
                    if (sram_we[g]) mem[sram_addr[g]] <= sram_wdata[g];
                    else            rd_q <= mem[sram_addr[g]];
                end
            end

            ahb_sram_slave #(
                .BUSD_WIDTH (8),
                .BUSA_WIDTH (24),
                .MEM_AW     (16),
                .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))
            ) u_dut (
                .clk       (clk),
                .hreset_n  (hreset_n[g]),
                .hsel      (hsel[g]),
                .haddr     (haddr[g]),
                .hwrite    (hwrite[g]),
                .hburst    (hburst[g]),
                .htrans    (htrans[g]),
                .hwdata    (hwdata[g]),
                .hready    (hready[g]),
                .hresp     (hresp[g]),
                .hrdata    (hrdata[g]),
                .sram_cs   (sram_cs[g]),
                .sram_we   (sram_we[g]),
                .sram_addr (sram_addr[g]),
                .sram_wdata(sram_wdata[g]),
                .sram_rdata(rd_q)
            );
        end
    endgenerate

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic drive_idle(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = HTRANS_IDLE;
        hwrite[k] = 1'b0;
        haddr[k]  = 24'h0;
        hwdata[k] = 8'h00;
        hburst[k] = HBURST_SINGLE;
    endtask

    // Queue one address-phase beat; real transfers also get a scoreboard entry.
    task automatic add_beat(input int k, input logic sel, input logic [1:0] tr,
                            input logic wr, input logic [23:0] addr, input logic [7:0] wd);
        beat_t b;
        exp_t  e;
        b.sel = sel; b.trans = tr; b.wr = wr; b.addr = addr; b.wdata = wd;
        bq.push_back(b);
        if (sel && tr[1]) begin
            e.is_err = |addr[23:16];
            e.wr     = wr;
            e.addr   = addr[15:0];
            e.wdata  = wd;
            e.rdata  = 8'h00;
            e.waits  = e.is_err ? 1 : (wr ? wait_of(k) : wait_of(k) + 1);
            if (!e.is_err) begin
                if (wr) ref_mem[k][addr[15:0]] = wd;
                else    e.rdata = ref_mem[k][addr[15:0]];
            end
            eq.push_back(e);
        end
    endtask

    // Pipelined master: runs queued beats on instance k, checking every cycle.
    task automatic run(input int k, output int cycles);
        beat_t a;
        exp_t  d;
        logic  d_valid;
        logic  from_q;
        logic  rdy;
        int    ws;
        d_valid = 1'b0;
        ws      = 0;
        cycles  = 0;
        while ((bq.size() != 0 || d_valid) && cycles < 500) begin
            from_q = (bq.size() != 0);
            if (from_q) a = bq[0];
            else begin
                a.sel = 1'b0; a.trans = HTRANS_IDLE; a.wr = 1'b0; a.addr = 24'h0; a.wdata = 8'h00;
            end
            hsel[k]   = a.sel;
            htrans[k] = a.trans;
            hwrite[k] = a.wr;
            haddr[k]  = a.addr;
            hwdata[k] = (d_valid && d.wr) ? d.wdata : 8'h00;
            @(negedge clk);
            rdy = hready[k];
            if (!d_valid) begin
                total++;
                if (rdy !== 1'b1 || hresp[k] !== 1'b0 || sram_cs[k] !== 1'b0 || hrdata[k] !== 8'h00) begin
                    bad++;
                    $display("FAIL idle_phase k=%0d: got hready=%b hresp=%b sram_cs=%b hrdata=%h, want 1 0 0 00",
                             k, rdy, hresp[k], sram_cs[k], hrdata[k]);
                end
            end else if (d.is_err) begin
                total++;
                if (hresp[k] !== 1'b1 || sram_cs[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL err_resp k=%0d: got hresp=%b sram_cs=%b, want 1 0", k, hresp[k], sram_cs[k]);
                end
                if (rdy !== 1'b1) ws++;
                else begin
                    total++;
                    if (ws !== 1) begin
                        bad++;
                        $display("FAIL err_len k=%0d: got %0d low cycles, want 1", k, ws);
                    end
                end
            end else if (rdy !== 1'b1) begin
                ws++;
                if (d.wr) begin
                    total++;
                    if (sram_cs[k] !== 1'b0) begin
                        bad++;
                        $display("FAIL wr_wait_cs k=%0d: got sram_cs=%b, want 0", k, sram_cs[k]);
                    end
                end
            end else begin
                total++;
                if (hresp[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL okay_resp k=%0d addr=%h: got hresp=%b, want 0", k, d.addr, hresp[k]);
                end
                total++;
                if (ws !== d.waits) begin
                    bad++;
                    $display("FAIL waits k=%0d addr=%h: got %0d, want %0d", k, d.addr, ws, d.waits);
                end
                if (d.wr) begin
                    total++;
                    if (sram_cs[k] !== 1'b1 || sram_we[k] !== 1'b1 || sram_addr[k] !== d.addr ||
                        sram_wdata[k] !== d.wdata) begin
                        bad++;
                        $display("FAIL wr_strobe k=%0d: got cs=%b we=%b addr=%h wdata=%h, want 1 1 %h %h",
                                 k, sram_cs[k], sram_we[k], sram_addr[k], sram_wdata[k], d.addr, d.wdata);
                    end
                end else begin
                    total++;
                    if (hrdata[k] !== d.rdata) begin
                        bad++;
                        $display("FAIL rdata k=%0d addr=%h: got %h, want %h", k, d.addr, hrdata[k], d.rdata);
                    end
                end
            end
            @(posedge clk);
            #1;
            cycles++;
            if (rdy === 1'b1) begin
                d_valid = 1'b0;
                if (from_q) begin
                    a = bq.pop_front();
                    if (a.sel && a.trans[1]) begin
                        d       = eq.pop_front();
                        d_valid = 1'b1;
                        ws      = 0;
                    end
                end
            end
        end
        if (cycles >= 500) begin
            total++;
            bad++;
            $display("FAIL timeout k=%0d: got %0d cycles, want < 500", k, cycles);
            bq.delete();
            eq.delete();
        end
        drive_idle(k);
    endtask

    task automatic test_reset();
        for (int k = 0; k < NI; k++) begin
            drive_idle(k);
            hreset_n[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (hready[k] !== 1'b1 || hresp[k] !== 1'b0 || hrdata[k] !== 8'h00 || sram_cs[k] !== 1'b0 ||
                sram_we[k] !== 1'b0 || sram_addr[k] !== 16'h0 || sram_wdata[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_state k=%0d: got rdy=%b resp=%b rd=%h cs=%b we=%b a=%h wd=%h, want 1 0 00 0 0 0000 00",
                         k, hready[k], hresp[k], hrdata[k], sram_cs[k], sram_we[k], sram_addr[k], sram_wdata[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) hreset_n[k] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_rw();
        int c;
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b1, 24'h000010, 8'hA5);
        add_beat(0, 1'b1, HTRANS_IDLE,   1'b0, 24'h000000, 8'h00);
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000010, 8'h00);
        run(0, c);
    endtask

    task automatic test_burst_wait();
        int c;
        hburst[1] = HBURST_INCR4;
        for (int i = 0; i < 4; i++)
            add_beat(1, 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, 24'h000100 + 24'(i), 8'(8'h11 * (i + 1)));
        for (int i = 0; i < 4; i++)
            add_beat(1, 1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, 24'h000100 + 24'(i), 8'h00);
        run(1, c);
        hburst[1] = HBURST_SINGLE;
    endtask

    task automatic test_error();
        int c;
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b1, 24'h000000, 8'h77);
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h010000, 8'h00);
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000000, 8'h00);
        run(0, c);
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b1, 24'hFF0000, 8'h99);
        add_beat(0, 1'b1, HTRANS_IDLE,   1'b0, 24'h000000, 8'h00);
        add_beat(0, 1'b1, HTRANS_IDLE,   1'b0, 24'h000000, 8'h00);
        run(0, c);
    endtask

    task automatic test_busy_desel();
        int c;
        hburst[1] = HBURST_INCR;
        add_beat(1, 1'b1, HTRANS_NONSEQ, 1'b1, 24'h000200, 8'hB1);
        add_beat(1, 1'b1, HTRANS_BUSY,   1'b1, 24'h000201, 8'h00);
        add_beat(1, 1'b1, HTRANS_SEQ,    1'b1, 24'h000201, 8'hB2);
        add_beat(1, 1'b0, HTRANS_NONSEQ, 1'b1, 24'h000300, 8'hEE);
        add_beat(1, 1'b1, HTRANS_SEQ,    1'b1, 24'h000202, 8'hB3);
        add_beat(1, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000200, 8'h00);
        add_beat(1, 1'b1, HTRANS_BUSY,   1'b0, 24'h000201, 8'h00);
        add_beat(1, 1'b1, HTRANS_SEQ,    1'b0, 24'h000201, 8'h00);
        add_beat(1, 1'b1, HTRANS_SEQ,    1'b0, 24'h000202, 8'h00);
        add_beat(1, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000300, 8'h00);
        run(1, c);
        hburst[1] = HBURST_SINGLE;
    endtask

    task automatic test_reset_in_flight();
        int c;
        hsel[2]   = 1'b1;
        htrans[2] = HTRANS_NONSEQ;
        hwrite[2] = 1'b0;
        haddr[2]  = 24'h000030;
        @(posedge clk);
        #1;
        drive_idle(2);
        @(negedge clk);
        total++;
        if (hready[2] !== 1'b0) begin
            bad++;
            $display("FAIL inflight_wait: got hready=%b, want 0", hready[2]);
        end
        @(posedge clk);
        #1;
        hreset_n[2] = 1'b0;
        @(posedge clk);
        #1;
        hreset_n[2] = 1'b1;
        @(negedge clk);
        total++;
        if (hready[2] !== 1'b1 || hresp[2] !== 1'b0 || sram_cs[2] !== 1'b0 || hrdata[2] !== 8'h00) begin
            bad++;
            $display("FAIL after_reset: got hready=%b hresp=%b sram_cs=%b hrdata=%h, want 1 0 0 00",
                     hready[2], hresp[2], sram_cs[2], hrdata[2]);
        end
        @(posedge clk);
        #1;
        add_beat(2, 1'b1, HTRANS_NONSEQ, 1'b1, 24'h000031, 8'hC3);
        add_beat(2, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000031, 8'h00);
        add_beat(2, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000030, 8'h00);
        run(2, c);
    endtask

    task automatic test_back_to_back();
        int c;
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b1, 24'h000020, 8'h5A);
        add_beat(0, 1'b1, HTRANS_NONSEQ, 1'b0, 24'h000020, 8'h00);
        run(0, c);
        total++;
        if (c !== 4) begin
            bad++;
            $display("FAIL b2b_cycles: got %0d cycles, want 4", c);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 65536; i++) ref_mem[k][i] = 8'h00;
        test_reset();
        test_single_rw();
        test_burst_wait();
        test_error();
        test_busy_desel();
        test_reset_in_flight();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
